sha256_compress: RTL and testbench
==================================

Name: sha256_compress

Overview:
- Consumer end of the SHA-256 message-schedule interface.
- Drives the schedule generator's enable, word index and index-complete signals, and receives one 32-bit schedule word W[t] per cycle on cur_w.
- Runs the 64 compression rounds on working variables a..h, then adds the chaining value to produce the 256-bit digest for one 512-bit block.
- Sits between the block padder/controller (start, hash_in) and the schedule generator instance.

Parameters:
- W_LENGTH, 64: number of rounds and schedule words; index width is $clog2(W_LENGTH).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin compressing one block; sampled only in IDLE.
- hash_in  input  256  chaining value H0..H7, H0 in bits [255:224]; latched on the accepted start.
- cur_w  input  32  schedule word from the generator; registered there, valid one cycle after its index is driven.
- w_vector_complete  input  1  generator's registered copy of w_index_complete.
- w_enable  output  1  schedule generator enable; high from PRIME through FINAL.
- w_vector_index  output  $clog2(W_LENGTH)  schedule word index requested this cycle.
- w_index_complete  output  1  high for exactly one cycle, when the last index (63) is driven.
- busy  output  1  high in any state other than IDLE.
- digest  output  256  result {H0'..H7'}, registered; holds its value until the next completion.
- digest_valid  output  1  one-cycle pulse when digest updates.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: state=IDLE, round counter=0. All outputs 0 (w_enable, w_vector_index, w_index_complete, busy, digest, digest_valid). Working registers a..h and h_save cleared.
- FSM states are IDLE, PRIME, ROUND, FINAL.
- IDLE: w_enable=0.
  - On start=1: load a..h and h_save from hash_in, set r=0, go to PRIME.
- PRIME (1 cycle): w_enable=1, w_vector_index=0. Next state ROUND, with index advanced to 1.
- ROUND (64 cycles, r=0..63):
  - cur_w holds W[r]. Compute T1 = h + Σ1(e) + Ch(e,f,g) + K[r] + W[r] and T2 = Σ0(a) + Maj(a,b,c).
  - Update h..a ← g,f,e,d+T1,c,b,a,T1+T2. All additions mod 2^32, carries discarded.
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25.
  - While r<63: drive w_vector_index=r+1.
  - At r=62 (index 63 driven): w_index_complete=1.
  - At r=63: index held at 63 (never wraps to 0), w_index_complete=0; next state FINAL.
- FINAL:
  - Wait until w_vector_complete=1. It arrives on the first FINAL cycle with a correct generator.
  - Then register digest = h_save[i] + {a..h}[i] per 32-bit word mod 2^32, pulse digest_valid, go to IDLE.
  - w_enable drops at that edge, which clears the generator.
- Latency: start sampled at edge E0 → digest_valid high in the cycle following edge E0+66. Minimum start-to-start spacing is 67 cycles.
- start while busy: ignored; no queuing.
- start held high continuously: a new block begins on the first IDLE cycle after digest_valid.
- Reset mid-operation: aborts immediately to IDLE. w_enable=0. digest is cleared and digest_valid is not pulsed.
- hash_in and start changes while busy have no effect.
- w_vector_complete outside FINAL is ignored.

Decomposition:
- Package sha256_pkg holds:
  - K[0:63] constant table and the IV constant (6a09e667 … 5be0cd19).
  - FSM state enum.
  - Functions rotr32, big_sigma0, big_sigma1, ch, maj.
- Sub-module sha256_round: purely combinational single round. Inputs a..h, k, w; outputs next a..h. Instantiated once.
- The top level owns the FSM, counter, registers and final addition.

Test Plan:
- Bench: this block connected to the schedule generator, hash_in=IV.
- "abc" block 61626380 00…00 00000018 → digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
  - digest_valid exactly 66 cycles after the start edge; w_index_complete high only while index=63.
- Empty-message block 80000000 00…00 → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Second start issued on the cycle after digest_valid, with hash_in=first digest.
  - Final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- start pulsed at rounds 10 and 40 of the "abc" run → ignored; same digest and same latency; busy stays high throughout.
- reset asserted at round 30 → next cycle all outputs 0 and w_enable=0. A fresh "abc" run afterwards yields the correct digest.
- w_vector_complete forced low for 5 cycles in FINAL → digest_valid delayed exactly 5 cycles; digest unchanged.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state encoding and the round helper functions
// used by the compression core and its single-round datapath.
package sha256_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_ROUND = 2'd2,
      ST_FINAL = 2'd3
   } state_t;

   localparam logic [255:0] SHA256_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] K_TABLE [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] n);
      logic [63:0] dbl;
      dbl = {x, x} >> n;
      return dbl[31:0];
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr32(x, 5'd2) ^ rotr32(x, 5'd13) ^ rotr32(x, 5'd22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr32(x, 5'd6) ^ rotr32(x, 5'd11) ^ rotr32(x, 5'd25);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// Link between the compression core (master) and the message-schedule
// generator (slave): index requests out, registered schedule words back.
interface sha256_compress_if #(parameter int W_LENGTH = 64);

   logic                          w_enable;
   logic [$clog2(W_LENGTH)-1:0]   w_vector_index;
   logic                          w_index_complete;
   logic [31:0]                   cur_w;
   logic                          w_vector_complete;

   modport master (
      output w_enable, w_vector_index, w_index_complete,
      input  cur_w, w_vector_complete
   );

   modport slave (
      input  w_enable, w_vector_index, w_index_complete,
      output cur_w, w_vector_complete
   );

endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: consumes a..h plus K[t] and W[t] and
// produces the shifted working variables for the next round.
module sha256_round
   import sha256_pkg::*;
(
   input  logic [31:0] a, b, c, d, e, f, g, h,
   input  logic [31:0] k,
   input  logic [31:0] w,
   output logic [31:0] next_a, next_b, next_c, next_d,
   output logic [31:0] next_e, next_f, next_g, next_h
);

   logic [31:0] t1_s;
   logic [31:0] t2_s;

   assign t1_s   = h + big_sigma1(e) + ch(e, f, g) + k + w;
   assign t2_s   = big_sigma0(a) + maj(a, b, c);

   assign next_a = t1_s + t2_s;
   assign next_b = a;
   assign next_c = b;
   assign next_d = c;
   assign next_e = d + t1_s;
   assign next_f = e;
   assign next_g = f;
   assign next_h = g;

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression of one 512-bit block: sequences the schedule generator,
// runs 64 rounds and folds the chaining value into a registered digest.
module sha256_compress
   import sha256_pkg::*;
#(
   parameter int W_LENGTH = 64
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [255:0]        hash_in,
   sha256_compress_if.master   sched,
   output logic                busy,
   output logic [255:0]        digest,
   output logic                digest_valid
);

   localparam int                IDX_W    = $clog2(W_LENGTH);
   localparam logic [IDX_W-1:0]  ZERO_IDX = IDX_W'(0);
   localparam logic [IDX_W-1:0]  ONE_IDX  = IDX_W'(1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(W_LENGTH - 1);
   localparam logic [IDX_W-1:0]  PEN_IDX  = IDX_W'(W_LENGTH - 2);
   localparam logic [IDX_W-1:0]  PRE_IDX  = IDX_W'(W_LENGTH - 3);

   state_t            state_r, state_s;
   logic [IDX_W-1:0]  round_r, round_s;
   logic [IDX_W-1:0]  index_r, index_s;
   logic [IDX_W:0]    index_ahead_s;
   logic              enable_r, enable_s;
   logic              idx_done_r, idx_done_s;
   logic              busy_r, busy_s;
   logic              valid_r, valid_s;
   logic              load_s, step_s, finish_s;
   logic [31:0]       work_r   [0:7];
   logic [31:0]       h_save_r [0:7];
   logic [31:0]       next_s   [0:7];
   logic [255:0]      digest_r, sum_s;

   sha256_round u_round (
      .a(work_r[0]), .b(work_r[1]), .c(work_r[2]), .d(work_r[3]),
      .e(work_r[4]), .f(work_r[5]), .g(work_r[6]), .h(work_r[7]),
      .k(K_TABLE[round_r]), .w(sched.cur_w),
      .next_a(next_s[0]), .next_b(next_s[1]), .next_c(next_s[2]), .next_d(next_s[3]),
      .next_e(next_s[4]), .next_f(next_s[5]), .next_g(next_s[6]), .next_h(next_s[7])
   );

   // Next state plus the next value of every registered handshake output.
   always_comb begin
      state_s       = state_r;
      round_s       = round_r;
      index_s       = index_r;
      enable_s      = enable_r;
      idx_done_s    = 1'b0;
      busy_s        = busy_r;
      valid_s       = 1'b0;
      load_s        = 1'b0;
      step_s        = 1'b0;
      finish_s      = 1'b0;
      index_ahead_s = {1'b0, round_r} + {{IDX_W{1'b0}}, 1'b1} + {{IDX_W{1'b0}}, 1'b1};
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s  = ST_PRIME;
               round_s  = ZERO_IDX;
               index_s  = ZERO_IDX;
               enable_s = 1'b1;
               busy_s   = 1'b1;
               load_s   = 1'b1;
            end else begin
               enable_s = 1'b0;
               busy_s   = 1'b0;
            end
         end
         ST_PRIME: begin
            state_s = ST_ROUND;
            index_s = ONE_IDX;
         end
         ST_ROUND: begin
            step_s     = 1'b1;
            // Registered index runs one ahead of the round and saturates at the last word.
            index_s    = (round_r >= PEN_IDX) ? LAST_IDX : index_ahead_s[IDX_W-1:0];
            idx_done_s = (round_r == PRE_IDX);
            if (round_r == LAST_IDX) begin
               state_s = ST_FINAL;
            end else begin
               round_s = round_r + ONE_IDX;
            end
         end
         ST_FINAL: begin
            if (sched.w_vector_complete) begin
               state_s  = ST_IDLE;
               index_s  = ZERO_IDX;
               enable_s = 1'b0;
               busy_s   = 1'b0;
               valid_s  = 1'b1;
               finish_s = 1'b1;
            end else begin
               state_s = ST_FINAL;
            end
         end
         default: begin
            state_s  = ST_IDLE;
            index_s  = ZERO_IDX;
            enable_s = 1'b0;
            busy_s   = 1'b0;
         end
      endcase
   end

   // Final chaining-value addition, word by word.
   always_comb begin
      sum_s = 256'd0;
      for (int i = 0; i < 8; i++) begin
         sum_s[255-32*i -: 32] = h_save_r[i] + work_r[i];
      end
   end

   // FSM, counters and handshake output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         round_r    <= ZERO_IDX;
         index_r    <= ZERO_IDX;
         enable_r   <= 1'b0;
         idx_done_r <= 1'b0;
         busy_r     <= 1'b0;
         valid_r    <= 1'b0;
      end else begin
         state_r    <= state_s;
         round_r    <= round_s;
         index_r    <= index_s;
         enable_r   <= enable_s;
         idx_done_r <= idx_done_s;
         busy_r     <= busy_s;
         valid_r    <= valid_s;
      end
   end

   // Working variables, saved chaining value and digest.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            work_r[i]   <= 32'd0;
            h_save_r[i] <= 32'd0;
         end
         digest_r <= 256'd0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (load_s) begin
               work_r[i]   <= hash_in[255-32*i -: 32];
               h_save_r[i] <= hash_in[255-32*i -: 32];
            end else if (step_s) begin
               work_r[i] <= next_s[i];
            end
         end
         if (finish_s) begin
            digest_r <= sum_s;
         end
      end
   end

   assign sched.w_enable         = enable_r;
   assign sched.w_vector_index   = index_r;
   assign sched.w_index_complete = idx_done_r;
   assign busy                   = busy_r;
   assign digest                 = digest_r;
   assign digest_valid           = valid_r;

endmodule

// File: tb/tb_sha256_compress.sv
// Directed bench: sha256_compress against a behavioural schedule generator,
// checking known FIPS 180 digests, latency, ignored starts, reset and stalls.
module tb_sha256_compress;
   import sha256_pkg::*;

   localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [511:0] MSG_ABC   = {32'h61626380, 448'd0, 32'h00000018};
   localparam logic [511:0] MSG_EMPTY = {32'h80000000, 480'd0};
   localparam logic [511:0] MSG_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] MSG_TWO2  = {480'd0, 32'h000001c0};

   logic         clock = 1'b0;
   logic         reset;
   logic         start;
   logic [255:0] hash_in;
   logic         busy;
   logic [255:0] digest;
   logic         digest_valid;

   logic [31:0]  sched_w [0:63];
   logic [31:0]  gen_w;
   logic         vc_r;
   logic         hold_vc;

   int checks = 0;
   int errors = 0;
   int ic_cnt;
   int lat;
   logic [255:0] first_dig;

   sha256_compress_if #(.W_LENGTH(64)) sif ();

   sha256_compress #(.W_LENGTH(64)) dut (
      .clock(clock), .reset(reset), .start(start), .hash_in(hash_in),
      .sched(sif.master), .busy(busy), .digest(digest), .digest_valid(digest_valid)
   );

   always #5 clock = ~clock;

   // Behavioural schedule generator: registered W[index] and sticky completion.
   always_ff @(posedge clock) begin
      if (reset || !sif.w_enable) begin
         gen_w <= 32'd0;
         vc_r  <= 1'b0;
      end else begin
         gen_w <= sched_w[sif.w_vector_index];
         vc_r  <= vc_r | sif.w_index_complete;
      end
   end
   assign sif.cur_w             = gen_w;
   assign sif.w_vector_complete = vc_r & ~hold_vc;

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic load_msg(input logic [511:0] m);
      logic [31:0] s0, s1;
      for (int t = 0; t < 16; t++) sched_w[t] = m[511-32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         s0 = rr(sched_w[t-15], 7) ^ rr(sched_w[t-15], 18) ^ (sched_w[t-15] >> 3);
         s1 = rr(sched_w[t-2], 17) ^ rr(sched_w[t-2], 19) ^ (sched_w[t-2] >> 10);
         sched_w[t] = s1 + sched_w[t-7] + s0 + sched_w[t-16];
      end
   endtask

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_digest"}, digest, 256'd0);
      chk({tag, "_valid"}, {255'd0, digest_valid}, 256'd0);
      chk({tag, "_busy"}, {255'd0, busy}, 256'd0);
      chk({tag, "_wen"}, {255'd0, sif.w_enable}, 256'd0);
      chk({tag, "_widx"}, {250'd0, sif.w_vector_index}, 256'd0);
      chk({tag, "_wic"}, {255'd0, sif.w_index_complete}, 256'd0);
   endtask

   // Start one block and follow it until digest_valid, an injected reset, or the cycle budget.
   task automatic run_block(input logic [255:0] hv, input logic [511:0] m, input int pulse_a,
                            input int pulse_b, input int reset_at, input int hold_until);
      @(negedge clock);
      load_msg(m);
      hash_in = hv;
      hold_vc = (hold_until > 0);
      start   = 1'b1;
      @(posedge clock); #1;
      start  = 1'b0;
      lat    = 0;
      ic_cnt = 0;
      for (int n = 1; n <= 150; n++) begin
         @(posedge clock); #1;
         if (n == hold_until) hold_vc = 1'b0;
         if (digest_valid) begin
            lat = n;
            break;
         end
         if (reset_at > 0 && n == reset_at) begin
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
            check_idle_outputs("midreset");
            lat = -1;
            break;
         end
         chk("busy_high", {255'd0, busy}, {255'd0, 1'b1});
         if (sif.w_index_complete) begin
            ic_cnt++;
            chk("wic_index", {250'd0, sif.w_vector_index}, 256'd63);
         end
         start = (n == pulse_a || n == pulse_b);
      end
      start = 1'b0;
      if (lat == 0) chk("timeout", 256'd0, 256'd1);
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      hash_in = 256'd0;
      hold_vc = 1'b0;
      for (int t = 0; t < 64; t++) sched_w[t] = 32'd0;
      repeat (3) @(posedge clock);
      #1;
      check_idle_outputs("reset");
      @(negedge clock);
      reset = 1'b0;

      // "abc": digest, latency, single index-complete pulse, then digest holds.
      run_block(SHA256_IV, MSG_ABC, 0, 0, 0, 0);
      chk("abc_latency", 256'(lat), 256'd66);
      chk("abc_wic_count", 256'(ic_cnt), 256'd1);
      chk("abc_digest", digest, DIG_ABC);
      @(posedge clock); #1;
      chk("abc_valid_pulse", {255'd0, digest_valid}, 256'd0);
      chk("abc_digest_hold", digest, DIG_ABC);
      chk("abc_idle_busy", {255'd0, busy}, 256'd0);

      // Empty message.
      run_block(SHA256_IV, MSG_EMPTY, 0, 0, 0, 0);
      chk("empty_latency", 256'(lat), 256'd66);
      chk("empty_digest", digest, DIG_EMPTY);

      // Two-block message, second start immediately after the first digest_valid.
      run_block(SHA256_IV, MSG_TWO1, 0, 0, 0, 0);
      chk("two1_latency", 256'(lat), 256'd66);
      first_dig = digest;
      run_block(first_dig, MSG_TWO2, 0, 0, 0, 0);
      chk("two2_latency", 256'(lat), 256'd66);
      chk("two_digest", digest, DIG_TWO);

      // Starts during rounds 10 and 40 are ignored.
      run_block(SHA256_IV, MSG_ABC, 11, 41, 0, 0);
      chk("pulse_latency", 256'(lat), 256'd66);
      chk("pulse_wic_count", 256'(ic_cnt), 256'd1);
      chk("pulse_digest", digest, DIG_ABC);

      // Reset at round 30, then a fresh run.
      run_block(SHA256_IV, MSG_ABC, 0, 0, 31, 0);
      chk("reset_taken", 256'(lat), 256'hffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff);
      repeat (2) @(posedge clock);
      run_block(SHA256_IV, MSG_ABC, 0, 0, 0, 0);
      chk("after_reset_latency", 256'(lat), 256'd66);
      chk("after_reset_digest", digest, DIG_ABC);

      // Completion withheld for the first 5 FINAL cycles.
      run_block(SHA256_IV, MSG_ABC, 0, 0, 0, 70);
      chk("stall_latency", 256'(lat), 256'd71);
      chk("stall_digest", digest, DIG_ABC);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
